// File: rtl/data_mem_lsu_if.sv
// Request/ready bus between the load/store unit and the data memory.
// The master drives the request; the slave returns data, ready, busy and fault.
interface data_mem_lsu_if;
  logic        req;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        busy;
  logic        misaligned;

  modport master (
    output req, we, size, addr, write_data,
    input  read_data, ready, busy, misaligned
  );

  modport slave (
    input  req, we, size, addr, write_data,
    output read_data, ready, busy, misaligned
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Word RAM with wait states, byte-lane stores and extended loads.
// DATA_MEM_MISALIGN_EXC_EN turns misaligned H/W accesses into faults.
module data_mem_lsu #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic          clk,
  input logic          rst,
  data_mem_lsu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        c_we;
  logic [2:0]  c_size;
  logic [AW+1:0] c_addr;
  logic [31:0] c_wdata;

  logic [31:0] mem [DEPTH];

  logic        is_b, is_h, is_w, sgn;
  logic        fault, wr_en;
  logic [3:0]  be;
  logic [31:0] wd, word, ld;
  logic [7:0]  byt;
  logic [15:0] half;
  logic [AW-1:0] idx;

  logic unused_addr;
  assign unused_addr = ^bus.addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      c_we    <= 1'b0;
      c_size  <= '0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && bus.req) begin
        c_we    <= bus.we;
        c_size  <= bus.size;
        c_addr  <= bus.addr[AW+1:0];
        c_wdata <= bus.write_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          cnt_nx   = 4'(WAIT_CYCLES);
          state_nx = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign is_b = (c_size == 3'b000) || (c_size == 3'b100);
  assign is_h = (c_size == 3'b001) || (c_size == 3'b101);
  assign is_w = (c_size == 3'b010);
  assign sgn  = ~c_size[2];

`ifdef DATA_MEM_MISALIGN_EXC_EN
  assign fault = (is_h & c_addr[0]) |
                 (is_w & (|c_addr[1:0]));
`else
  assign fault = 1'b0;
`endif

  assign idx  = c_addr[AW+1:2];
  assign word = mem[idx];
  assign byt  = word[{c_addr[1:0], 3'b000} +: 8];
  assign half = c_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    be = 4'b0000;
    wd = c_wdata;
    ld = '0;
    unique case (1'b1)
      is_b: begin
        be = 4'b0001 << c_addr[1:0];
        wd = {4{c_wdata[7:0]}};
        ld = {{24{sgn & byt[7]}}, byt};
      end
      is_h: begin
        be = c_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{c_wdata[15:0]}};
        ld = {{16{sgn & half[15]}}, half};
      end
      is_w: begin
        be = 4'b1111;
        ld = word;
      end
      default: ;
    endcase
  end

  // Write lands on the edge that leaves DONE, so a reset there aborts it
  assign wr_en = (state == DONE) & c_we & ~fault & ~rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign bus.ready      = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.misaligned = bus.ready & fault;
  assign bus.read_data  = (bus.ready & ~c_we & ~fault) ? ld : '0;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one instance with no wait states
// and one with three, sharing the clock.
module tb_data_mem_lsu;
  logic clk = 1'b0;
  logic rst0, rst3;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  data_mem_lsu_if bus0 ();
  data_mem_lsu_if bus3 ();

  data_mem_lsu #(.DEPTH(1024), .WAIT_CYCLES(0)) u0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  data_mem_lsu #(.DEPTH(1024), .WAIT_CYCLES(3)) u3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    bus0.we = w; bus0.size = sz; bus0.addr = a; bus0.write_data = d;
    bus3.we = w; bus3.size = sz; bus3.addr = a; bus3.write_data = d;
  endtask

  task automatic acc(input bit sel, input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic mis,
                     output int lat);
    logic rdy;
    drive(w, sz, a, d);
    if (sel) bus3.req = 1'b1;
    else     bus0.req = 1'b1;
    @(posedge clk); #1;
    bus0.req = 1'b0;
    bus3.req = 1'b0;
    lat = 1;
    rdy = sel ? bus3.ready : bus0.ready;
    while (!rdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      rdy = sel ? bus3.ready : bus0.ready;
    end
    rd  = sel ? bus3.read_data  : bus0.read_data;
    mis = sel ? bus3.misaligned : bus0.misaligned;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        mis;
  int          lat, bcnt, rcnt;

  initial begin
    bus0.req = 1'b0;
    bus3.req = 1'b0;
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    rst0 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, bus0.ready}, 32'd0);
    chk("rst_busy0", {31'd0, bus0.busy}, 32'd0);
    chk("rst_mis0", {31'd0, bus0.misaligned}, 32'd0);
    chk("rst_rdata0", bus0.read_data, 32'd0);
    chk("rst_busy3", {31'd0, bus3.busy}, 32'd0);
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(posedge clk); #1;

    acc(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, mis, lat);
    chk("sw_lat", lat, 1);
    acc(0, 0, 3'b010, 32'h10, 32'h0, rd, mis, lat);
    chk("lw_lat", lat, 1);
    chk("lw_10", rd, 32'hDEADBEEF);

    acc(0, 1, 3'b000, 32'h11, 32'h0000007F, rd, mis, lat);
    acc(0, 0, 3'b010, 32'h10, 32'h0, rd, mis, lat);
    chk("sb_lw", rd, 32'hDEAD7FEF);
    acc(0, 0, 3'b000, 32'h13, 32'h0, rd, mis, lat);
    chk("lb_13", rd, 32'hFFFFFFDE);
    acc(0, 0, 3'b100, 32'h13, 32'h0, rd, mis, lat);
    chk("lbu_13", rd, 32'h000000DE);

    acc(0, 1, 3'b001, 32'h12, 32'h00008001, rd, mis, lat);
    acc(0, 0, 3'b001, 32'h12, 32'h0, rd, mis, lat);
    chk("lh_12", rd, 32'hFFFF8001);
    acc(0, 0, 3'b101, 32'h12, 32'h0, rd, mis, lat);
    chk("lhu_12", rd, 32'h00008001);
    acc(0, 0, 3'b010, 32'h10, 32'h0, rd, mis, lat);
    chk("sh_lw", rd, 32'h80017FEF);

    acc(0, 0, 3'b011, 32'h10, 32'h0, rd, mis, lat);
    chk("bad_ld", rd, 32'h0);
    chk("bad_lat", lat, 1);
    acc(0, 1, 3'b111, 32'h10, 32'hFFFFFFFF, rd, mis, lat);
    acc(0, 0, 3'b010, 32'h10, 32'h0, rd, mis, lat);
    chk("bad_st", rd, 32'h80017FEF);
    acc(0, 0, 3'b010, 32'h1010, 32'h0, rd, mis, lat);
    chk("wrap", rd, 32'h80017FEF);

    acc(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, rd, mis, lat);
    acc(0, 0, 3'b010, 32'h22, 32'h0, rd, mis, lat);
`ifdef DATA_MEM_MISALIGN_EXC_EN
    chk("mis_lw_rd", rd, 32'h0);
    chk("mis_lw_flag", {31'd0, mis}, 32'd1);
`else
    chk("mis_lw_rd", rd, 32'hCAFEF00D);
    chk("mis_lw_flag", {31'd0, mis}, 32'd0);
`endif
    acc(0, 1, 3'b010, 32'h21, 32'h11111111, rd, mis, lat);
    acc(0, 0, 3'b010, 32'h20, 32'h0, rd, mis, lat);
`ifdef DATA_MEM_MISALIGN_EXC_EN
    chk("mis_sw", rd, 32'hCAFEF00D);
`else
    chk("mis_sw", rd, 32'h11111111);
`endif
    acc(0, 0, 3'b001, 32'h23, 32'h0, rd, mis, lat);
`ifdef DATA_MEM_MISALIGN_EXC_EN
    chk("mis_lh", rd, 32'h0);
`else
    chk("mis_lh", rd, 32'h00001111);
`endif

    acc(1, 1, 3'b010, 32'h20, 32'hA5A5A5A5, rd, mis, lat);
    chk("w3_sw_lat", lat, 4);

    drive(1'b0, 3'b010, 32'h20, 32'h0);
    bus3.req = 1'b1;
    @(posedge clk); #1;
    lat  = 1;
    bcnt = 0;
    while (lat < 20) begin
      if (bus3.busy) bcnt++;
      if (bus3.ready) break;
      if (lat == 2) begin
        bus3.addr = 32'h40;
        bus3.we   = 1'b1;
        bus3.size = 3'b000;
      end
      @(posedge clk); #1;
      lat++;
    end
    rd = bus3.read_data;
    bus3.req = 1'b0;
    chk("w3_lat", lat, 4);
    chk("w3_busy", bcnt, 4);
    chk("w3_rd", rd, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("w3_pulse", {31'd0, bus3.ready}, 32'd0);
    chk("w3_idle", {31'd0, bus3.busy}, 32'd0);

    drive(1'b1, 3'b010, 32'h20, 32'h12345678);
    bus3.req = 1'b1;
    @(posedge clk); #1;
    bus3.req = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    rcnt = 0;
    repeat (6) begin
      if (bus3.ready) rcnt++;
      @(posedge clk); #1;
    end
    chk("abort_ready", rcnt, 0);
    chk("abort_busy", {31'd0, bus3.busy}, 32'd0);
    acc(1, 0, 3'b010, 32'h20, 32'h0, rd, mis, lat);
    chk("abort_lw", rd, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
